// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel word assembler, LSB first, optional even parity (DESERIALIZER_PARITY_EN)
module deserializer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         I,
  input  logic         VLD,
  input  logic         FRM,
  output logic [W-1:0] O,
  output logic         OVLD,
  output logic         ERR
);

  localparam int CW = $clog2(W + 1);

`ifdef DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [W-1:0]    o_q, o_d;
  logic            ovld_q, ovld_d;
  logic            err_q, err_d;
  logic [W-1:0]    bit_word;

  assign O    = o_q;
  assign OVLD = ovld_q;
  assign ERR  = err_q;

  // Next-state logic: word assembly, framing restart and completion pulses
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    o_d      = o_q;
    ovld_d   = 1'b0;
    err_d    = 1'b0;
    // partial word with the incoming bit placed at the current count
    bit_word = shreg_q;
    for (int b = 0; b < W; b++) begin
      if (cnt_q == CW'(b)) bit_word[b] = I;
    end

    case (state_q)
      IDLE: begin
        if (VLD && FRM) begin
          shreg_d = {{(W-1){1'b0}}, I};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (VLD) begin
          if (FRM) begin
            // frame marker mid-word: drop the partial word and restart on this bit
            err_d   = 1'b1;
            shreg_d = {{(W-1){1'b0}}, I};
            cnt_d   = CW'(1);
          end else if (cnt_q == CW'(W - 1)) begin
            shreg_d = bit_word;
`ifdef DESERIALIZER_PARITY_EN
            cnt_d   = CW'(W);
            state_d = PAR;
`else
            o_d     = bit_word;
            ovld_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            shreg_d = bit_word;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
`ifdef DESERIALIZER_PARITY_EN
      PAR: begin
        if (VLD) begin
          if (FRM) begin
            err_d   = 1'b1;
            shreg_d = {{(W-1){1'b0}}, I};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            // even parity: trailing bit equals XOR of the data bits
            if (I == ^shreg_q) begin
              o_d    = shreg_q;
              ovld_d = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset wins over any same-cycle input
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      o_q     <= '0;
      ovld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      o_q     <= o_d;
      ovld_q  <= ovld_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - table-driven bench for deserializer (W=8)
module tb_deserializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         i_bit;
  logic         vld;
  logic         frm;
  logic [W-1:0] o;
  logic         ovld;
  logic         err;

  deserializer #(.W(W)) dut (
    .CLK  (clk),
    .RST  (rst),
    .I    (i_bit),
    .VLD  (vld),
    .FRM  (frm),
    .O    (o),
    .OVLD (ovld),
    .ERR  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         vld;
    logic         frm;
    logic         i;
    logic [W-1:0] exp_o;
    logic         exp_ovld;
    logic         exp_err;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    n_checks;
  int    n_fail;

  // one vector = inputs for an edge and the outputs required just after it
  task automatic push(input string nm, input logic r, input logic v, input logic f,
                      input logic b, input logic [W-1:0] eo, input logic eov,
                      input logic eer);
    vec_t x;
    x.rst = r; x.vld = v; x.frm = f; x.i = b;
    x.exp_o = eo; x.exp_ovld = eov; x.exp_err = eer;
    vecs.push_back(x);
    names.push_back(nm);
  endtask

  task automatic idle(input string nm, input int n, input logic [W-1:0] eo);
    for (int k = 0; k < n; k++) push(nm, 1'b0, 1'b0, 1'b0, 1'b0, eo, 1'b0, 1'b0);
  endtask

  // full frame of word w; first_err marks a framing restart on bit 0
  task automatic frame(input string nm, input logic [W-1:0] w, input int gap,
                       input logic [W-1:0] o_prev, input logic first_err);
    for (int b = 0; b < W; b++) begin
`ifdef DESERIALIZER_PARITY_EN
      push(nm, 1'b0, 1'b1, (b == 0), w[b], o_prev, 1'b0, (b == 0) && first_err);
`else
      if (b == W - 1)
        push(nm, 1'b0, 1'b1, 1'b0, w[b], w, 1'b1, 1'b0);
      else
        push(nm, 1'b0, 1'b1, (b == 0), w[b], o_prev, 1'b0, (b == 0) && first_err);
`endif
      if (b != W - 1) idle(nm, gap, o_prev);
    end
`ifdef DESERIALIZER_PARITY_EN
    idle(nm, gap, o_prev);
    push(nm, 1'b0, 1'b1, 1'b0, ^w, w, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    logic [W-1:0] junk;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; vld = 1'b0; frm = 1'b0; i_bit = 1'b0;
    junk = 8'hFF;

    // reset state
    push("reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    // 8'h4D, VLD continuous, frame straight after reset
    frame("word_4d", 8'h4D, 0, 8'h00, 1'b0);
    idle("after_4d", 2, 8'h4D);
    // same word with 3-cycle VLD gaps
    push("reset2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    frame("gap_4d", 8'h4D, 3, 8'h00, 1'b0);
    // VLD without FRM in IDLE is ignored
    push("idle_nofrm", 1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 1'b0);
    push("idle_nofrm", 1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0);
    // 5 bits, then FRM at bit 5 restarts with 8'hA5
    for (int b = 0; b < 5; b++)
      push("pre_restart", 1'b0, 1'b1, (b == 0), junk[b], 8'h4D, 1'b0, 1'b0);
    frame("restart_a5", 8'hA5, 0, 8'h4D, 1'b1);
    idle("after_a5", 1, 8'hA5);
    // back-to-back frames 8'h01 then 8'hFF
    frame("b2b_01", 8'h01, 0, 8'hA5, 1'b0);
    frame("b2b_ff", 8'hFF, 0, 8'h01, 1'b0);
    idle("after_ff", 1, 8'hFF);
    // reset after 4 bits, with VLD/FRM active on the reset edge
    for (int b = 0; b < 4; b++)
      push("pre_rst", 1'b0, 1'b1, (b == 0), junk[b], 8'hFF, 1'b0, 1'b0);
    push("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    frame("word_3c", 8'h3C, 0, 8'h00, 1'b0);
    idle("after_3c", 1, 8'h3C);
`ifdef DESERIALIZER_PARITY_EN
    // 8'h4D with wrong parity: ERR, O keeps 8'h3C
    for (int b = 0; b < W; b++)
      push("bad_par", 1'b0, 1'b1, (b == 0), 8'h4D >> b, 8'h3C, 1'b0, 1'b0);
    push("bad_par", 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    // FRM on the parity slot is a framing error and restarts
    frame("good_par", 8'h4D, 0, 8'h3C, 1'b0);
    for (int b = 0; b < W; b++)
      push("par_frm", 1'b0, 1'b1, (b == 0), 1'b0, 8'h4D, 1'b0, 1'b0);
    frame("par_restart", 8'h96, 0, 8'h4D, 1'b1);
`endif
    idle("tail", 2, vecs[vecs.size()-1].exp_o);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst   = vecs[k].rst;
      vld   = vecs[k].vld;
      frm   = vecs[k].frm;
      i_bit = vecs[k].i;
      @(posedge clk);
      #1;
      n_checks++;
      if (o !== vecs[k].exp_o || ovld !== vecs[k].exp_ovld || err !== vecs[k].exp_err) begin
        n_fail++;
        $display("FAIL %s vec %0d: got O=%h OVLD=%b ERR=%b, expected O=%h OVLD=%b ERR=%b",
                 names[k], k, o, ovld, err, vecs[k].exp_o, vecs[k].exp_ovld, vecs[k].exp_err);
      end
      n_checks++;
      if (ovld === 1'b1 && err === 1'b1) begin
        n_fail++;
        $display("FAIL excl vec %0d: got OVLD=1 ERR=1, expected not both", k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter W, default 8, data word width in bits (legal range 2..16).
REQ-002 CLK  input  1  clock, all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 I  input  1  serial data bit, LSB first.
REQ-005 VLD  input  1  bit-valid qualifier; I is sampled only on edges where VLD=1.
REQ-006 FRM  input  1  frame-start marker; meaningful only when VLD=1, marks I as bit 0 of a new word.
REQ-007 O  output  W  last completed parallel word, registered.
REQ-008 OVLD  output  1  one-cycle pulse: O updated this cycle.
REQ-009 ERR  output  1  one-cycle pulse: framing or parity error.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and (PARITY_EN only) PAR.
REQ-011 IDLE: on VLD=1 & FRM=1, the FSM SHALL store I as bit 0, set bit count to 1 and go to SHIFT; VLD=1 & FRM=0 SHALL be ignored with no error.
REQ-012 SHIFT: each VLD=1 & FRM=0 edge SHALL store I at bit position count and increment count; VLD=0 edges SHALL hold all state.
REQ-013 When bit W-1 is stored: without PARITY_EN, O SHALL load the assembled word, OVLD SHALL pulse the next cycle and the FSM SHALL return to IDLE; with PARITY_EN, the FSM SHALL go to PAR instead.
REQ-014 PAR: on VLD=1, I is the even-parity bit; match → load O and pulse OVLD; mismatch → pulse ERR, O unchanged, no OVLD; both cases return to IDLE.
REQ-015 FRM=1 with VLD=1 in SHIFT or PAR SHALL pulse ERR, discard the partial word, keep O, and restart with I as bit 0 (count=1, SHIFT).
REQ-016 Latency: OVLD/ERR SHALL be high in the cycle immediately after the edge that sampled the final bit.
REQ-017 Back-to-back frames: a FRM bit arriving on the cycle after the final bit SHALL be accepted with no dead cycle; the OVLD pulse of the previous word SHALL coincide with it.
REQ-018 OVLD and ERR SHALL never be high in the same cycle.
REQ-019 Count SHALL be ceil(log2(W+1)) bits and SHALL never exceed W.
REQ-020 All outputs SHALL be driven directly from flip-flops (no combinational path from inputs).

Reset
REQ-021 On RST=1 at a rising CLK edge: state=IDLE, count=0, O=0, OVLD=0, ERR=0.
REQ-022 RST mid-frame SHALL discard the partial word with no OVLD or ERR pulse; RST has priority over VLD/FRM in the same cycle.
REQ-023 The first frame SHALL be accepted on the first edge after RST deasserts.

Configuration
REQ-024 Macro DESERIALIZER_PARITY_EN: defined → PAR state and trailing even-parity bit per word (W+1 bits per frame); undefined → no PAR state, W bits per frame, ERR driven only by framing errors.

Verification
REQ-025 W=8, no parity: FRM+VLD with bits 1,0,1,1,0,0,1,0 LSB first, VLD continuous → O=8'h4D, OVLD one cycle after the 8th bit, ERR=0.
REQ-026 Same word with VLD=0 gaps of 3 cycles between bits → identical O=8'h4D, OVLD timing relative to the last VLD bit unchanged.
REQ-027 FRM reasserted at bit 5 of a frame, then 8 bits of 8'hA5 → ERR pulse at restart+1, then O=8'hA5 with OVLD; O unchanged between.
REQ-028 PARITY_EN defined: 8'h4D + parity 0 → OVLD, O=8'h4D; 8'h4D + parity 1 → ERR, O keeps previous value.
REQ-029 Two frames 8'h01, 8'hFF back-to-back with no idle cycle → two OVLD pulses 8 cycles apart, O=8'h01 then 8'hFF.
REQ-030 RST asserted after 4 bits of a frame → O=0, OVLD=0, ERR=0; next full frame 8'h3C received correctly.
